// File: rtl/rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding,
// line-level constants and the parity helper.
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Word is zero-extended to 16 bits; the extra zeros leave the XOR unchanged.
    function automatic logic parity_mismatch(input logic [15:0] word,
                                             input logic        pbit,
                                             input logic        odd);
        return ((^{word, pbit}) != odd);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Per-bit cycle counter with synchronous clear; ticks are registered and
// reflect the counter value in the same cycle (mid-bit and last cycle of bit).
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic mid_tick,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          mid_tick_r;
    logic          bit_tick_r;

    // Next counter value: clear wins, otherwise wrap at the end of a bit.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (clr) begin
            cnt_nx_s = '0;
        end else if (cnt_r == LAST) begin
            cnt_nx_s = '0;
        end else begin
            cnt_nx_s = cnt_r + CW'(1);
        end
    end

    // Counter and tick registers; ticks are precomputed from the next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            mid_tick_r <= 1'b0;
            bit_tick_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_nx_s;
            mid_tick_r <= (cnt_nx_s == MID);
            bit_tick_r <= (cnt_nx_s == LAST);
        end
    end

    assign mid_tick = mid_tick_r;
    assign bit_tick = bit_tick_r;

endmodule

// File: rtl/rx_frame_receiver.sv
// Asynchronous serial frame receiver: synchroniser, frame FSM, shift register
// and a one-deep valid/ready output register with framing/parity/overrun flags.
module rx_frame_receiver
    import rx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] rx_word,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int BCW = $clog2(DATA_BITS + 1);

    logic                 sync1_r, rxs_r;
    rx_state_e            state_r, state_nx_s;
    logic [BCW-1:0]       bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r, rx_word_r;
    logic                 rx_valid_r, frame_err_r, parity_err_r, overrun_err_r, busy_r;
    logic                 stop_bad_r, parity_bad_r;
    logic                 clr_s, mid_tick_s, bit_tick_s;
    logic                 last_data_s, last_stop_s, done_s, frame_bad_s;

    // Data and parity bits are sampled one full bit after the start-bit mid
    // sample, so after START the timer is used at its last-cycle tick.
    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .mid_tick (mid_tick_s),
        .bit_tick (bit_tick_s)
    );

    assign last_data_s = (bit_cnt_r == BCW'(DATA_BITS - 1));
    assign last_stop_s = (bit_cnt_r == BCW'(STOP_BITS - 1));
    assign frame_bad_s = stop_bad_r || (rxs_r != STOP_LEVEL);
    assign done_s      = rx_en && (state_r == ST_STOP) && bit_tick_s && last_stop_s;
    assign clr_s       = (state_nx_s != state_r) || (state_r == ST_IDLE);

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx_data;
            rxs_r   <= sync1_r;
        end
    end

    // Frame FSM next-state decision.
    always_comb begin
        state_nx_s = state_r;
        if (!rx_en) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rxs_r == START_LEVEL) state_nx_s = ST_START;
                    else                      state_nx_s = ST_IDLE;
                end
                ST_START: begin
                    if (mid_tick_s) state_nx_s = (rxs_r == START_LEVEL) ? ST_DATA : ST_IDLE;
                    else            state_nx_s = ST_START;
                end
                ST_DATA: begin
                    if (bit_tick_s && last_data_s)
                        state_nx_s = (PARITY_EN != 32'sd0) ? ST_PARITY : ST_STOP;
                    else
                        state_nx_s = ST_DATA;
                end
                ST_PARITY: begin
                    if (bit_tick_s) state_nx_s = ST_STOP;
                    else            state_nx_s = ST_PARITY;
                end
                ST_STOP: begin
                    if (bit_tick_s && last_stop_s)
                        state_nx_s = frame_bad_s ? ST_WAIT_IDLE : ST_IDLE;
                    else
                        state_nx_s = ST_STOP;
                end
                ST_WAIT_IDLE: begin
                    if (rxs_r == STOP_LEVEL) state_nx_s = ST_IDLE;
                    else                     state_nx_s = ST_WAIT_IDLE;
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, bit counter, shift register, error tracking and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            bit_cnt_r     <= '0;
            shift_r       <= '0;
            stop_bad_r    <= 1'b0;
            parity_bad_r  <= 1'b0;
            rx_word_r     <= '0;
            rx_valid_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);

            if (clr_s) begin
                bit_cnt_r <= '0;
            end else if (bit_tick_s && ((state_r == ST_DATA) || (state_r == ST_STOP))) begin
                bit_cnt_r <= bit_cnt_r + BCW'(1);
            end

            if ((state_r == ST_DATA) && bit_tick_s) begin
                shift_r <= {rxs_r, shift_r[DATA_BITS-1:1]};
            end

            if (state_r == ST_IDLE) begin
                parity_bad_r <= 1'b0;
                stop_bad_r   <= 1'b0;
            end else begin
                if ((state_r == ST_PARITY) && bit_tick_s)
                    parity_bad_r <= parity_mismatch(16'(shift_r), rxs_r, 1'(PARITY_ODD));
                if ((state_r == ST_STOP) && bit_tick_s)
                    stop_bad_r <= stop_bad_r || (rxs_r != STOP_LEVEL);
            end

            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_err_r <= 1'b0;
            if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            // Completion outcome; a word accepted this cycle frees the register.
            if (done_s) begin
                if (frame_bad_s) begin
                    frame_err_r <= 1'b1;
                end else if (parity_bad_r) begin
                    parity_err_r <= 1'b1;
                end else if (!rx_valid_r || rx_ready) begin
                    rx_word_r  <= shift_r;
                    rx_valid_r <= 1'b1;
                end else begin
                    overrun_err_r <= 1'b1;
                end
            end
        end
    end

    assign rx_word     = rx_word_r;
    assign rx_valid    = rx_valid_r;
    assign frame_err   = frame_err_r;
    assign parity_err  = parity_err_r;
    assign overrun_err = overrun_err_r;
    assign busy        = busy_r;

endmodule
